// File: rtl/frontier_stream_to_onchip_writer.sv
// -----------------------------------------------------------------------------
// frontier_stream_to_onchip_writer
//
// Purpose:
//   Captures one 8-bit Avalon-ST packet per software start and writes it,
//   packed little-endian into 32-bit words, into a single-port on-chip RAM
//   (Avalon-MM slave, byte-enabled) starting at a programmed word address.
//   A trailing partial word is written with only its filled lanes enabled.
//   The address pointer wraps at DEPTH-1. Once DEPTH words have been written
//   for a packet, further words are dropped and a sticky overflow flag is
//   raised, while the rest of the packet is still consumed.
//
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   ctl_start           pulse; arms capture of the next packet (IDLE only)
//   ctl_base            start word address, sampled on an accepted start
//   ctl_busy            high while a packet is armed or in progress
//   ctl_done            one-cycle pulse with the packet's final write slot
//   ctl_words           words written for the current/last packet (sat DEPTH)
//   ctl_overflow        sticky overflow flag, cleared by an accepted start
//   st_data/valid/ready/sop/eop   8-bit Avalon-ST sink
//   mem_address/byteenable/chipselect/write/writedata/clken   RAM master
// -----------------------------------------------------------------------------
module frontier_stream_to_onchip_writer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  ctl_start,
    input  logic [ADDR_WIDTH-1:0] ctl_base,
    output logic                  ctl_busy,
    output logic                  ctl_done,
    output logic [ADDR_WIDTH:0]   ctl_words,
    output logic                  ctl_overflow,

    input  logic [7:0]            st_data,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic                  st_sop,
    input  logic                  st_eop,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [31:0]           mem_writedata,
    output logic                  mem_clken
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOP = 2'd1,
        PACK     = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   WORDS_MAX = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH:0]   words_q;
    logic                  ovf_q;
    logic                  done_q;
    logic [1:0]            lane_q;
    logic [31:0]           asm_q;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-1:0] mem_address_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;

    // Next-cycle views of the packing datapath for the beat on the bus now.
    logic                  take_d;
    logic                  issue_d;
    logic                  full_d;
    logic [1:0]            lane_d;
    logic [31:0]           asm_d;
    logic [3:0]            be_d;
    logic [ADDR_WIDTH-1:0] ptr_d;

    always_comb begin
        lane_d  = 2'd0;
        asm_d   = 32'd0;
        be_d    = 4'b0001;
        take_d  = 1'b0;
        issue_d = 1'b0;

        // In WAIT_SOP only a sop beat is kept; in PACK every beat is data,
        // including a stray sop. A sop beat always starts from lane 0.
        if (state_q == PACK) begin
            lane_d = lane_q;
            asm_d  = asm_q;
        end
        take_d  = st_valid & busy_q &
                  ((state_q == PACK) | ((state_q == WAIT_SOP) & st_sop));
        asm_d   = asm_d | ({24'd0, st_data} << {lane_d, 3'b000});
        issue_d = take_d & ((lane_d == 2'd3) | st_eop);

        // Lanes fill contiguously from 0, so the enable mask is a thermometer.
        case (lane_d)
            2'd0:    be_d = 4'b0001;
            2'd1:    be_d = 4'b0011;
            2'd2:    be_d = 4'b0111;
            default: be_d = 4'b1111;
        endcase

        full_d = (words_q == WORDS_MAX);
        ptr_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            ptr_q         <= '0;
            words_q       <= '0;
            ovf_q         <= 1'b0;
            done_q        <= 1'b0;
            lane_q        <= 2'd0;
            asm_q         <= 32'd0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            be_q          <= 4'b0000;
            wdata_q       <= 32'd0;
        end else begin
            // Write strobe and done are single-cycle; lanes/data read as zero
            // whenever no write is presented.
            mem_write_q <= 1'b0;
            be_q        <= 4'b0000;
            wdata_q     <= 32'd0;
            done_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (ctl_start) begin
                        ptr_q   <= ctl_base;
                        words_q <= '0;
                        ovf_q   <= 1'b0;
                        lane_q  <= 2'd0;
                        asm_q   <= 32'd0;
                        state_q <= WAIT_SOP;
                        busy_q  <= 1'b1;
                    end
                end

                WAIT_SOP, PACK: begin
                    if (take_d) begin
                        if (issue_d) begin
                            // Past DEPTH words the write is dropped but the
                            // packet keeps draining so eop still ends it.
                            if (full_d) begin
                                ovf_q <= 1'b1;
                            end else begin
                                mem_write_q   <= 1'b1;
                                mem_address_q <= ptr_q;
                                be_q          <= be_d;
                                wdata_q       <= asm_d;
                                ptr_q         <= ptr_d;
                                words_q       <= words_q + 1'b1;
                            end
                            asm_q  <= 32'd0;
                            lane_q <= 2'd0;
                        end else begin
                            asm_q  <= asm_d;
                            lane_q <= lane_d + 2'd1;
                        end

                        if (st_eop) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= PACK;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ctl_busy       = busy_q;
    assign st_ready       = busy_q;
    assign ctl_done       = done_q;
    assign ctl_words      = words_q;
    assign ctl_overflow   = ovf_q;
    assign mem_address    = mem_address_q;
    assign mem_byteenable = be_q;
    assign mem_write      = mem_write_q;
    assign mem_chipselect = mem_write_q;
    assign mem_writedata  = wdata_q;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_frontier_stream_to_onchip_writer.sv
// -----------------------------------------------------------------------------
// Testbench for frontier_stream_to_onchip_writer.
// Expected RAM writes are derived from each packet's byte list and base
// address and queued; a monitor pops and compares whenever the DUT presents
// a write or a done pulse.
// -----------------------------------------------------------------------------
module tb_frontier_stream_to_onchip_writer;

    localparam int AW          = 10;
    localparam int DEPTH       = 1024;
    localparam int BEAT_BUDGET = 20000;

    logic          clk;
    logic          reset_n;
    logic          ctl_start;
    logic [AW-1:0] ctl_base;
    logic          ctl_busy;
    logic          ctl_done;
    logic [AW:0]   ctl_words;
    logic          ctl_overflow;
    logic [7:0]    st_data;
    logic          st_valid;
    logic          st_ready;
    logic          st_sop;
    logic          st_eop;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic          mem_clken;

    frontier_stream_to_onchip_writer #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ctl_start      (ctl_start),
        .ctl_base       (ctl_base),
        .ctl_busy       (ctl_busy),
        .ctl_done       (ctl_done),
        .ctl_words      (ctl_words),
        .ctl_overflow   (ctl_overflow),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eop         (st_eop),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
        bit            wr;
        bit            done;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pkt_bytes[$];
    int         tests = 0;
    int         fails = 0;
    int         done_seen = 0;
    int         exp_words;
    bit         exp_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write slot or done pulse must match the next expectation.
    always @(negedge clk) begin
        if (reset_n && (mem_write || ctl_done)) begin
            if (ctl_done) done_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got we=%0b done=%0b addr=0x%0h data=0x%0h, expected none",
                         mem_write, ctl_done, mem_address, mem_writedata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_strobe", 64'(mem_write), 64'(e.wr));
                check("done_pulse", 64'(ctl_done), 64'(e.done));
                if (e.wr) begin
                    check("wr_addr", 64'(mem_address), 64'(e.addr));
                    check("wr_data", 64'(mem_writedata), 64'(e.data));
                    check("wr_be", 64'(mem_byteenable), 64'(e.be));
                    check("chipselect", 64'(mem_chipselect), 64'(1));
                end
                if (e.done) check("busy_at_done", 64'(ctl_busy), 64'(0));
            end
        end
    end

    // Reference model: chop the packet into 4-byte groups; group k lands at
    // (base+k) mod DEPTH unless DEPTH words have already been written.
    task automatic expect_packet(input int base, input int n);
        int nw;
        nw = (n + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            exp_t e;
            int   cnt;
            cnt    = (k == nw - 1) ? (n - 4 * k) : 4;
            e.data = 32'd0;
            for (int j = 0; j < cnt; j++)
                e.data = e.data | (32'(pkt_bytes[4 * k + j]) << (8 * j));
            e.be   = 4'((1 << cnt) - 1);
            e.addr = AW'((base + k) % DEPTH);
            e.wr   = (k < DEPTH);
            e.done = (k == nw - 1);
            if (e.wr || e.done) exp_q.push_back(e);
        end
        exp_words = (nw > DEPTH) ? DEPTH : nw;
        exp_ovf   = (nw > DEPTH);
    endtask

    task automatic fill_bytes(input int n, input bit counting);
        pkt_bytes.delete();
        for (int i = 0; i < n; i++)
            pkt_bytes.push_back(counting ? 8'(i + 1) : 8'($urandom));
    endtask

    task automatic start_pkt(input int base);
        ctl_base  = AW'(base);
        ctl_start = 1'b1;
        @(negedge clk);
        ctl_start = 1'b0;
        check("start_busy", 64'(ctl_busy), 64'(1));
        check("start_ready", 64'(st_ready), 64'(1));
        check("start_ovf_clr", 64'(ctl_overflow), 64'(0));
        check("start_words_clr", 64'(ctl_words), 64'(0));
    endtask

    // Drives n_junk non-sop beats, then the packet; inputs change on negedge.
    task automatic send_beats(input int n_junk, input int n, input int gap_pct,
                              input int mid_at, input bit with_eop);
        int idx, budget, total;
        bit fire, mid_done;
        idx = 0; budget = 0; total = n_junk + n; mid_done = 0;
        while (idx < total && budget < BEAT_BUDGET) begin
            ctl_start = 1'b0;
            if (!mid_done && mid_at >= 0 && idx == mid_at) begin
                ctl_start = 1'b1;
                ctl_base  = AW'($urandom);
                mid_done  = 1;
            end
            if (int'($urandom_range(99)) < gap_pct) begin
                st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_data = 8'($urandom);
            end else begin
                st_valid = 1'b1;
                if (idx < n_junk) begin
                    st_data = 8'($urandom); st_sop = 1'b0; st_eop = 1'b0;
                end else begin
                    st_data = pkt_bytes[idx - n_junk];
                    st_sop  = (idx == n_junk);
                    st_eop  = with_eop && (idx == total - 1);
                end
            end
            fire = st_valid && st_ready;
            @(negedge clk);
            if (fire) idx++;
            budget++;
        end
        st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; ctl_start = 1'b0;
        check("beat_budget", 64'(idx), 64'(total));
    endtask

    task automatic finish_pkt();
        repeat (4) @(negedge clk);
        check("drained", 64'(exp_q.size()), 64'(0));
        check("end_busy", 64'(ctl_busy), 64'(0));
        check("end_ready", 64'(st_ready), 64'(0));
        check("end_words", 64'(ctl_words), 64'(exp_words));
        check("end_ovf", 64'(ctl_overflow), 64'(exp_ovf));
    endtask

    task automatic run_packet(input int base, input int n_junk, input int gap_pct, input int mid_at);
        expect_packet(base, pkt_bytes.size());
        start_pkt(base);
        send_beats(n_junk, pkt_bytes.size(), gap_pct, mid_at, 1'b1);
        finish_pkt();
    endtask

    initial begin
        int   dseen;
        exp_t e;
        reset_n = 1'b0; ctl_start = 1'b0; ctl_base = '0;
        st_data = 8'd0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ready", 64'(st_ready), 64'(0));
        check("rst_busy", 64'(ctl_busy), 64'(0));
        check("rst_write", 64'(mem_write), 64'(0));
        check("rst_cs", 64'(mem_chipselect), 64'(0));
        check("rst_be", 64'(mem_byteenable), 64'(0));
        check("rst_addr", 64'(mem_address), 64'(0));
        check("rst_data", 64'(mem_writedata), 64'(0));
        check("rst_done", 64'(ctl_done), 64'(0));
        check("rst_ovf", 64'(ctl_overflow), 64'(0));
        check("rst_words", 64'(ctl_words), 64'(0));
        check("clken", 64'(mem_clken), 64'(1));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two full words at 0x010.
        fill_bytes(8, 1);
        run_packet('h010, 0, 0, -1);

        // Partial trailing word, then a single-byte sop+eop packet.
        fill_bytes(6, 1);
        run_packet('h000, 0, 0, -1);
        pkt_bytes.delete(); pkt_bytes.push_back(8'hAA);
        run_packet('h123, 0, 0, -1);

        // Leading junk beats and valid gaps must not change the words.
        fill_bytes(8, 1);
        run_packet('h010, 3, 40, -1);

        // Address wrap at the top of the RAM.
        fill_bytes(8, 1);
        run_packet('h3FF, 0, 0, -1);

        // Start pulse mid-packet is ignored.
        fill_bytes(12, 0);
        run_packet('h155, 0, 20, 6);

        // Random packets.
        for (int p = 0; p < 5; p++) begin
            fill_bytes(int'($urandom_range(1, 20)), 0);
            run_packet(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)), 30, -1);
        end

        // Overflow: 1025 words from base 0, last one dropped, done still pulses.
        fill_bytes(4100, 0);
        run_packet(0, 0, 0, -1);

        // Next start clears overflow; close it with a one-byte packet.
        pkt_bytes.delete(); pkt_bytes.push_back(8'h5C);
        run_packet('h200, 0, 0, -1);

        // Reset after 5 bytes: only the first full word is written, no done.
        fill_bytes(5, 0);
        e.addr = AW'('h040);
        e.data = {pkt_bytes[3], pkt_bytes[2], pkt_bytes[1], pkt_bytes[0]};
        e.be   = 4'hF; e.wr = 1; e.done = 0;
        exp_q.push_back(e);
        start_pkt('h040);
        send_beats(0, 5, 0, -1, 1'b0);
        dseen   = done_seen;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_busy", 64'(ctl_busy), 64'(0));
        check("abort_ready", 64'(st_ready), 64'(0));
        check("abort_words", 64'(ctl_words), 64'(0));
        for (int i = 0; i < 10; i++) begin
            st_valid = 1'b1; st_data = 8'($urandom); st_eop = (i == 9);
            @(negedge clk);
        end
        st_valid = 1'b0; st_eop = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_drained", 64'(exp_q.size()), 64'(0));
        check("abort_no_done", 64'(done_seen), 64'(dseen));
        check("abort_idle", 64'(ctl_busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frontier_stream_to_onchip_writer.md
Name: frontier_stream_to_onchip_writer

Overview:
Upstream feeder for the 1024x32 single-port on-chip RAM (Avalon-MM slave, byte-enabled, clken).
- Accepts one packet per software start on an 8-bit Avalon-ST sink (sop/eop framing).
- Packs bytes little-endian into 32-bit words and writes them into the RAM from a programmed base word address, with partial-word byteenables.
- Reports busy, done, word count and overflow to a control/status wrapper.

Parameters:
ADDR_WIDTH, 10, RAM word-address width; must match the RAM's address port.
DEPTH, 1024, RAM depth in words; the address pointer wraps at DEPTH-1 and overflow is declared past DEPTH words.

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  reset; synchronous, active-low
ctl_start  in  1  single-cycle pulse; arms capture of the next packet
ctl_base  in  ADDR_WIDTH  start word address, sampled on accepted ctl_start
ctl_busy  out  1  high whenever state != IDLE
ctl_done  out  1  one-cycle pulse, coincident with the packet's final write
ctl_words  out  ADDR_WIDTH+1  words written for current/last packet, saturates at DEPTH
ctl_overflow  out  1  sticky; cleared by accepted ctl_start
st_data  in  8  stream byte
st_valid  in  1  stream beat valid
st_ready  out  1  sink ready
st_sop  in  1  start of packet
st_eop  in  1  end of packet
mem_address  out  ADDR_WIDTH  RAM word address
mem_byteenable  out  4  lane enables; bit n covers writedata[8n+7:8n]
mem_chipselect  out  1  equals mem_write
mem_write  out  1  write strobe, one cycle per word
mem_writedata  out  32  packed word
mem_clken  out  1  RAM clock enable; constant 1

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE; st_ready, mem_write, mem_chipselect, mem_byteenable, mem_address, mem_writedata, ctl_done, ctl_overflow all 0; ctl_words 0; lane index 0; assembly register cleared.
- Reset mid-packet aborts the packet: no further writes and no done pulse.
- A beat is accepted when st_valid & st_ready.
- States:
  - IDLE: st_ready=0. On ctl_start: latch ctl_base into pointer, clear ctl_words and ctl_overflow, go to WAIT_SOP.
  - WAIT_SOP: st_ready=1. Accepted beats with st_sop=0 are discarded. An accepted sop beat stores its byte in lane 0 and goes to PACK; if that beat also has eop, the word is flushed and the state goes to IDLE.
  - PACK: st_ready=1. Each accepted byte goes into the current lane, lane index 0..3. st_sop inside PACK is ignored (byte treated as data).
- Word issue: triggered when an accepted beat fills lane 3 or carries eop.
  - On the NEXT cycle: mem_write=1, writedata = assembled word with unfilled lanes 0, byteenable = filled lanes (for example 4'b0011 for 2 bytes), address = pointer.
  - Pointer then increments mod DEPTH, ctl_words increments, and the assembly register and lane index reset.
  - Issue does not stall the sink: sustained throughput is 1 byte/cycle, and st_ready stays 1 through issue cycles within a packet.
- End of packet: an eop beat moves the state to IDLE in the same edge. Its write is issued the following cycle with ctl_done=1. ctl_busy is already 0 in that cycle.
- Overflow: if a word would be issued while ctl_words==DEPTH, the write is suppressed (mem_write=0), ctl_overflow=1, ctl_words holds DEPTH, and bytes are still accepted until eop. ctl_done still pulses at eop.
- ctl_start while busy is ignored. ctl_base is sampled only on an accepted start.
- Outputs are registered. mem_write is a single-cycle pulse per word; byteenable and writedata are don't-care-zero when mem_write=0.

Test Plan:
- Base 0x010, packet of 8 bytes 0x01..0x08, continuous valid -> writes (0x010, 0x04030201, be F) and (0x011, 0x08070605, be F); ctl_done with the second write; ctl_words=2; ctl_overflow=0.
- Base 0x000, 6 bytes 0x01..0x06 -> second write data 0x00000605, be 0x3; single-byte sop+eop packet 0xAA -> data 0x000000AA, be 0x1.
- Three non-sop beats before sop, plus random st_valid gaps -> the three beats are dropped; words are identical to the gap-free run; no write before the sop packet completes a word.
- Base 0x3FF, 8 bytes -> addresses 0x3FF then 0x000 (wrap); ctl_words=2.
- Base 0, 4100-byte packet -> exactly 1024 writes; 1025th suppressed; ctl_overflow=1; ctl_words=1024; done pulses. Next ctl_start clears overflow.
- reset_n=0 after 5 bytes of a packet -> no further mem_write; ctl_busy=0, ctl_done never pulses. ctl_start asserted mid-packet in a normal run -> ignored; pointer unchanged.
